// File: rtl/syscall_print_unit.sv
// Syscall output engine: serialises integer/string print requests into a byte stream.
// Optional SYSCALL_NEWLINE_EN appends 8'h0A after every print request.
module syscall_print_unit #(
    parameter int DATA_W    = 32,
    parameter int N_WORDS   = 4,
    parameter int CODE_UINT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_code,
    input  logic [N_WORDS*DATA_W-1:0] req_arg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_char,
    output logic                      busy,
    output logic                      halted,
    output logic                      err_pulse
);

    localparam int BPW   = DATA_W / 8;
    localparam int DIG_N = (DATA_W * 30103 + 99999) / 100000 + 1;
    localparam int PW    = $clog2(DIG_N);
    localparam int WW    = $clog2(N_WORDS + 1);
    localparam int BW    = $clog2(BPW + 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        EMIT_SIGN,
        EMIT_INT,
        EMIT_STR,
`ifdef SYSCALL_NEWLINE_EN
        EMIT_NL,
`endif
        HALT
    } state_t;

    state_t                      state;
    logic                        live;
    logic [N_WORDS*DATA_W-1:0]   arg_q;
    logic [DATA_W-1:0]           mag;
    logic                        neg;
    logic [3:0]                  dig_buf [DIG_N];
    logic [PW-1:0]               pos;
    logic [WW-1:0]               word_i;
    logic [WW-1:0]               word_last;
    logic [BW-1:0]               byte_i;

    logic [DATA_W-1:0]           quo;
    logic [3:0]                  digit;
    logic                        xfer;
    logic                        is_uint;
    logic                        is_str;

    function automatic logic [7:0] ascii(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [7:0] pick(input logic [N_WORDS*DATA_W-1:0] a,
                                        input logic [WW-1:0] w,
                                        input logic [BW-1:0] b);
        return a[int'(w) * DATA_W + int'(b) * 8 +: 8];
    endfunction

    always_comb begin
        quo     = mag / DATA_W'(10);
        digit   = 4'(mag - quo * DATA_W'(10));
        xfer    = out_valid && out_ready;
        is_uint = (req_code == 32'(CODE_UINT));
        is_str  = (req_code >= 32'd4) && (req_code <= 32'(3 + N_WORDS));
    end

    // live keeps req_ready low while reset is asserted and for the edge it is released on
    assign req_ready = live && (state == IDLE);
    assign halted    = (state == HALT);
    assign busy      = (state != IDLE) && (state != HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            live      <= 1'b0;
            arg_q     <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            pos       <= '0;
            word_i    <= '0;
            word_last <= '0;
            byte_i    <= '0;
            out_valid <= 1'b0;
            out_char  <= '0;
            err_pulse <= 1'b0;
            for (int unsigned i = 0; i < DIG_N; i++) dig_buf[i] <= '0;
        end else begin
            live      <= 1'b1;
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (live && req_valid) begin
                        arg_q <= req_arg;
                        pos   <= '0;
                        if (is_uint) begin
                            mag   <= req_arg[DATA_W-1:0];
                            neg   <= 1'b0;
                            state <= CONV;
                        end else if (req_code == 32'd1) begin
                            neg   <= req_arg[DATA_W-1];
                            mag   <= req_arg[DATA_W-1] ? -req_arg[DATA_W-1:0]
                                                       : req_arg[DATA_W-1:0];
                            state <= CONV;
                        end else if (req_code == 32'd2) begin
                            state <= HALT;
                        end else if (req_code == 32'd3) begin
                            state <= IDLE;
                        end else if (is_str) begin
                            word_last <= WW'(req_code - 32'd4);
                            word_i    <= '0;
                            byte_i    <= BW'(BPW - 1);
                            out_char  <= req_arg[DATA_W-1 -: 8];
                            out_valid <= 1'b1;
                            state     <= EMIT_STR;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                end
                // pos stops on the most significant digit, which is emitted straight from digit
                CONV: begin
                    dig_buf[pos] <= digit;
                    mag          <= quo;
                    if (quo == '0) begin
                        out_valid <= 1'b1;
                        if (neg) begin
                            out_char <= 8'h2D;
                            state    <= EMIT_SIGN;
                        end else begin
                            out_char <= ascii(digit);
                            state    <= EMIT_INT;
                        end
                    end else begin
                        pos <= pos + 1'b1;
                    end
                end
                EMIT_SIGN: begin
                    if (xfer) begin
                        out_char <= ascii(dig_buf[pos]);
                        state    <= EMIT_INT;
                    end
                end
                EMIT_INT: begin
                    if (xfer) begin
                        if (pos == '0) begin
`ifdef SYSCALL_NEWLINE_EN
                            out_char  <= 8'h0A;
                            state     <= EMIT_NL;
`else
                            out_valid <= 1'b0;
                            state     <= IDLE;
`endif
                        end else begin
                            pos      <= pos - 1'b1;
                            out_char <= ascii(dig_buf[PW'(pos - 1'b1)]);
                        end
                    end
                end
                EMIT_STR: begin
                    if (xfer) begin
                        if (byte_i == '0) begin
                            if (word_i == word_last) begin
`ifdef SYSCALL_NEWLINE_EN
                                out_char  <= 8'h0A;
                                state     <= EMIT_NL;
`else
                                out_valid <= 1'b0;
                                state     <= IDLE;
`endif
                            end else begin
                                word_i   <= word_i + 1'b1;
                                byte_i   <= BW'(BPW - 1);
                                out_char <= pick(arg_q, word_i + 1'b1, BW'(BPW - 1));
                            end
                        end else begin
                            byte_i   <= byte_i - 1'b1;
                            out_char <= pick(arg_q, word_i, byte_i - 1'b1);
                        end
                    end
                end
`ifdef SYSCALL_NEWLINE_EN
                EMIT_NL: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
`endif
                HALT: state <= HALT;
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_print_unit.sv
// Scoreboard bench for syscall_print_unit: directed requests, expected bytes queued,
// a negedge monitor pops and compares every transferred character.
module tb_syscall_print_unit;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_code = '0;
    logic [127:0] req_arg = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_char;
    logic         busy;
    logic         halted;
    logic         err_pulse;

    syscall_print_unit #(.DATA_W(32), .N_WORDS(4), .CODE_UINT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_arg   (req_arg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .busy      (busy),
        .halted    (halted),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

`ifdef SYSCALL_NEWLINE_EN
    localparam int NL = 1;
`else
    localparam int NL = 0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_acc = 0;
    int         first_cyc = 0;
    int         last_cyc = 0;
    int         xfer_cnt = 0;
    bit         seen_first = 0;
    bit         bp_mode = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_char = '0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = bp_mode ? ~out_ready : 1'b1;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_char !== prev_char) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%b char=%h, required valid=1 char=%h",
                             out_valid, out_char, prev_char);
                end
            end
            if (out_valid && !seen_first) begin
                seen_first = 1;
                first_cyc  = cyc;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_char: got %h, required no output", out_char);
                end else begin
                    e = exp_q.pop_front();
                    if (out_char !== e) begin
                        n_err++;
                        $display("FAIL char: got %h, required %h", out_char, e);
                    end
                end
                last_cyc = cyc;
                xfer_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_char  = out_char;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_str(input string s, input bit nl);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        if (nl && NL == 1) exp_q.push_back(8'h0A);
    endtask

    task automatic send(input logic [31:0] c, input logic [127:0] a);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) chk("send_ready_timeout", 0, 1);
        seen_first = 0;
        xfer_cnt   = 0;
        req_valid  = 1'b1;
        req_code   = c;
        req_arg    = a;
        @(posedge clk);
        #1;
        t_acc     = cyc;
        req_valid = 1'b0;
        req_code  = 32'd9;
        req_arg   = '1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk({name, "_timeout"}, 0, 1);
        chk({name, "_ready_after"}, req_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] words;
        int n;
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] words;
        int n;
        words = {"MNOP", "IJKL", "EFGH", "ABCD"};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err_pulse", err_pulse, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        push_str("-1001", 1);
        send(32'd1, 128'(-32'sd1001) & 128'hFFFF_FFFF);
        wait_done("signed");
        chk("signed_first_latency", first_cyc - t_acc, 4);
        chk("signed_no_gap", last_cyc - first_cyc, 4 + NL);

        push_str("4294966295", 1);
        send(32'd8, 128'hFFFF_FC17);
        wait_done("unsigned");
        chk("unsigned_first_latency", first_cyc - t_acc, 10);

        push_str("0", 1);
        send(32'd1, 128'h0);
        wait_done("zero");
        chk("zero_first_latency", first_cyc - t_acc, 1);

        push_str("-2147483648", 1);
        send(32'd1, 128'h8000_0000);
        wait_done("int_min");

        bp_mode = 1;
        push_str("ABCDEFGHIJKLMNOP", 1);
        send(32'd7, words);
        wait_done("str4");
        chk("str4_first_latency", first_cyc - t_acc, 0);
        push_str("ABCDEFGH", 1);
        send(32'd5, words);
        wait_done("str2");
        bp_mode = 0;
        @(posedge clk);
        #1;

        send(32'd3, words);
        chk("nop_busy", busy, 0);
        chk("nop_err", err_pulse, 0);
        chk("nop_ready", req_ready, 1);
        send(32'd9, words);
        chk("unknown_err", err_pulse, 1);
        chk("unknown_busy", busy, 0);
        @(posedge clk);
        #1 chk("unknown_err_single", err_pulse, 0);

        send(32'd2, '0);
        chk("exit_halted", halted, 1);
        chk("exit_ready", req_ready, 0);
        chk("exit_busy", busy, 0);
        req_valid = 1'b1;
        req_code  = 32'd1;
        req_arg   = 128'd5;
        repeat (20) @(posedge clk);
        #1 req_valid = 1'b0;
        chk("halt_sticky", halted, 1);
        chk("halt_ignored_busy", busy, 0);
        chk("halt_ignored_valid", out_valid, 0);

        reset = 1'b0;
        #2 chk("reset_clears_halt", halted, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        push_str("ABC", 0);
        send(32'd6, words);
        n = 0;
        while (xfer_cnt < 3 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50) chk("partial_timeout", 0, 1);
        #1 reset = 1'b0;
        #1 chk("reset_mid_valid", out_valid, 0);
        chk("reset_mid_busy", busy, 0);
        chk("reset_mid_drained", exp_q.size(), 0);
        exp_q.delete();
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        push_str("WXYZ", 1);
        send(32'd4, {96'h0, "WXYZ"});
        wait_done("wxyz");

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/syscall_print_unit.md
Name: syscall_print_unit

Overview:
- Sequential syscall output engine behind the system_top syscall path (instruction ID 26).
- Accepts one syscall request per handshake and serialises it into a byte-wide character stream for the console/log sink.
- Generalises the fixed display syscalls with three additions: parametrised integer width, parametrised string word count, and valid/ready backpressure on both sides.
- Supported requests: print signed integer, print unsigned integer, print packed string, exit, nop.

Parameters:
- DATA_W, 32, width of integer argument and of each string word; multiple of 8, range 8..64.
- N_WORDS, 4, maximum string words per request (1..8).
- CODE_UINT, 8, syscall code for unsigned integer print.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous, active-low reset.
- req_valid, input, 1, syscall request present.
- req_ready, output, 1, unit can accept a request.
- req_code, input, 32, syscall code (the rs value).
- req_arg, input, N_WORDS*DATA_W, argument words; word0 (rt1) in the LSBs, word k in bits [k*DATA_W +: DATA_W].
- out_valid, output, 1, out_char holds a valid character.
- out_ready, input, 1, sink accepts the character.
- out_char, output, 8, ASCII character.
- busy, output, 1, a request is in progress.
- halted, output, 1, exit syscall executed; sticky until reset.
- err_pulse, output, 1, one-cycle pulse on an unknown code.

Behaviour:
- Codes, resolved in priority order:
  - CODE_UINT: unsigned integer print.
  - 1: signed integer print.
  - 2: exit.
  - 3: nop.
  - 4..4+N_WORDS-1: string print of (code-3) words. If a string code equals CODE_UINT, CODE_UINT wins.
  - Any other code: unknown.
- Reset (asynchronous assert, synchronous deassert use): all outputs 0; FSM to IDLE; digit buffer cleared. A reset mid-request drops the request; out_valid falls immediately.
- States: IDLE, CONV, EMIT_SIGN, EMIT_INT, EMIT_STR, EMIT_NL (macro only), HALT.
- Request handshake:
  - req_ready = 1 only in IDLE with halted = 0.
  - Accept on req_valid && req_ready at cycle T. req_code and req_arg are registered at T; later input changes are ignored.
- Signed/unsigned integer print:
  - Magnitude is taken in DATA_W-bit unsigned. The most negative value (e.g. 0x80000000) prints correctly.
  - CONV produces one decimal digit per cycle, LSB-first, into a digit buffer of ceil(DATA_W*0.30103)+1 entries. Division is by constant 10.
  - Zero yields a single digit.
  - Emission starts at cycle T+D+1, where D is the digit count. Order: '-' first if signed and negative (EMIT_SIGN), then digits MSB-first (EMIT_INT).
- String print:
  - First char is valid at T+1.
  - Order: word0 MSB byte first, then down to LSB byte, then word1, and so on; 4 bytes per word when DATA_W=32, DATA_W/8 generally.
  - All bytes are emitted, including NUL.
- Output handshake:
  - A char transfers on out_valid && out_ready.
  - While out_valid && !out_ready, out_char and out_valid hold stable.
  - Back-to-back transfers are allowed: one char per cycle with out_ready held at 1.
- Completion: after the last char transfers, go to IDLE next cycle; busy=0 and req_ready=1 in that cycle.
- Nop: accepted, no output, IDLE at T+1.
- Unknown code: err_pulse=1 at T+1, then treated as nop.
- Exit: HALT at T+1 with halted=1, req_ready=0, busy=0. Remains there until reset; further req_valid is ignored.
- busy = 1 in every state except IDLE and HALT.

Optional Feature:
- Macro: SYSCALL_NEWLINE_EN.
- Defined: after the last char of every print request, EMIT_NL sends one extra character 8'h0A under the same handshake. Nop, exit and unknown codes emit nothing.
- Undefined: no EMIT_NL state; output is exactly the digits, sign and string bytes.

Test Plan:
- Signed print: code 1, arg -1001, out_ready=1 -> chars "-1001" (5 transfers), no gap between chars, then req_ready=1.
- Unsigned print: code 8, arg -1001 (0xFFFFFC17) -> "4294966295". Also arg 0 with code 1 -> "0"; arg 0x80000000 with code 1 -> "-2147483648".
- String print under backpressure: code 7, words "ABCD","EFGH","IJKL","MNOP", out_ready toggling every cycle -> "ABCDEFGHIJKLMNOP"; out_char constant during every stall cycle. Code 5 with the same args -> "ABCDEFGH".
- Control codes: code 3, then code 9 -> no chars; err_pulse=1 for one cycle on code 9 only. Then code 2 -> halted=1 at T+1, req_ready=0; a following code 1 request is never accepted.
- Reset mid-request: code 6 in progress after 3 chars, reset driven low -> out_valid=0 the same cycle. After release, a new code 4 "WXYZ" prints "WXYZ".
- SYSCALL_NEWLINE_EN defined: code 4 "ABCD" -> "ABCD" followed by 8'h0A; code 3 -> no output.
